// File: rtl/bram_read_arbiter_pkg.sv
// Shared constants and types for the BRAM read arbiter slice.
// Image geometry, BRAM sizing and requester identities live here.
package bram_read_arbiter_pkg;

  localparam int ADDR_W      = 19;
  localparam int DATA_W      = 8;
  localparam int IMG_ROW     = 540;
  localparam int IMG_COL     = 540;
  localparam int BRAM_RD_LAT = 2;

  // Requester identities; also used as the round-robin pointer value
  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_HOST  = 1'b1
  } req_id_e;

  // One slot of the read-latency pipeline
  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rd_tag_t;

endpackage

// File: rtl/bram_read_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the BRAM port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface bram_read_arbiter_if #(
  parameter int ADDR_W = bram_read_arbiter_pkg::ADDR_W,
  parameter int DATA_W = bram_read_arbiter_pkg::DATA_W
);

  logic              req0_i;
  logic              req1_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [ADDR_W-1:0] addr1_i;
  logic              lock0_i;
  logic              gnt0_o;
  logic              gnt1_o;
  logic              rvalid0_o;
  logic              rvalid1_o;
  logic [DATA_W-1:0] rdata_o;
  logic              busy_o;
  logic              ena_o;
  logic              wea_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] d2mem_o;
  logic [DATA_W-1:0] mem2d_i;

  modport slave (
    input  req0_i, req1_i, addr0_i, addr1_i, lock0_i, mem2d_i,
    output gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata_o, busy_o,
    output ena_o, wea_o, addr_o, d2mem_o
  );

  modport master (
    output req0_i, req1_i, addr0_i, addr1_i, lock0_i, mem2d_i,
    input  gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata_o, busy_o,
    input  ena_o, wea_o, addr_o, d2mem_o
  );

endinterface

// File: rtl/bram_read_arbiter_rd_latency_pipe.sv
// Shift register that tracks which requester owns each read in flight.
// A tag pushed in the grant cycle pops out DEPTH cycles later, lined up
// with the BRAM read data. DEPTH is expected to be 1..4.
module rd_latency_pipe
  import bram_read_arbiter_pkg::*;
#(
  parameter int DEPTH = BRAM_RD_LAT
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_valid,
  input  req_id_e push_id,
  output rd_tag_t pop_tag,
  output logic    busy
);

  rd_tag_t stage [DEPTH];

  // Shift tags one stage per clock; reset discards every in-flight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '{valid: 1'b0, id: REQ_FETCH};
      end
    end else begin
      stage[0] <= '{valid: push_valid, id: push_id};
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Busy whenever any stage still carries a live read
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy = busy | stage[i].valid;
    end
  end

  assign pop_tag = stage[DEPTH-1];

endmodule

// File: rtl/bram_read_arbiter.sv
// Two-requester read arbiter in front of a single-port image BRAM.
// Requester 0 is the image fetch stream (may lock bursts), requester 1 is
// host/debug readback. Grants are combinational; data returns RD_LAT later.
module bram_read_arbiter #(
  parameter int ADDR_W = bram_read_arbiter_pkg::ADDR_W,
  parameter int DATA_W = bram_read_arbiter_pkg::DATA_W,
  parameter int RD_LAT = bram_read_arbiter_pkg::BRAM_RD_LAT
) (
  input logic                 clk,
  input logic                 rst_n,
  bram_read_arbiter_if.slave  bus
);

  import bram_read_arbiter_pkg::*;

  req_id_e rr_ptr;
  logic    last_gnt0;
  logic    gnt0;
  logic    gnt1;
  rd_tag_t out_tag;
  logic    pipe_busy;

  // Pick at most one winner: lock continuation, then round-robin, then sole requester
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (last_gnt0 && bus.lock0_i && bus.req0_i) begin
        gnt0 = 1'b1;
      end else if (bus.req0_i && bus.req1_i) begin
        gnt0 = (rr_ptr == REQ_FETCH);
        gnt1 = (rr_ptr == REQ_HOST);
      end else begin
        gnt0 = bus.req0_i;
        gnt1 = bus.req1_i;
      end
    end
  end

  // Pointer moves to the loser after every grant; remember whether requester 0 won
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= REQ_FETCH;
      last_gnt0 <= 1'b0;
    end else begin
      last_gnt0 <= gnt0;
      if (gnt0) begin
        rr_ptr <= REQ_HOST;
      end else if (gnt1) begin
        rr_ptr <= REQ_FETCH;
      end
    end
  end

  rd_latency_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_latency_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (gnt0 | gnt1),
    .push_id    (gnt1 ? REQ_HOST : REQ_FETCH),
    .pop_tag    (out_tag),
    .busy       (pipe_busy)
  );

  assign bus.gnt0_o    = gnt0;
  assign bus.gnt1_o    = gnt1;
  assign bus.ena_o     = gnt0 | gnt1;
  assign bus.addr_o    = gnt0 ? bus.addr0_i : (gnt1 ? bus.addr1_i : '0);
  assign bus.wea_o     = 1'b0;
  assign bus.d2mem_o   = '0;
  assign bus.rvalid0_o = out_tag.valid && (out_tag.id == REQ_FETCH);
  assign bus.rvalid1_o = out_tag.valid && (out_tag.id == REQ_HOST);
  assign bus.rdata_o   = out_tag.valid ? bus.mem2d_i : '0;
  assign bus.busy_o    = pipe_busy;

endmodule
